// File: rtl/setpoint_ramp_sel.sv
// setpoint_ramp_sel: selects one of NUM_SP preset setpoints and slews y toward it at a bounded rate.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset (y = target = INIT, IDLE)
//   sp_bus     packed presets, entry k at bits [k*WIDTH +: WIDTH]
//   sel        preset index, values >= NUM_SP select entry NUM_SP-1
//   sel_valid  one-cycle strobe that captures the selected preset as the new target
//   step       largest change of y per ramp tick (0 behaves as 1)
//   y          registered active setpoint
//   busy       high while ramping
//   done       one-cycle pulse when y arrives at the target
//
// Build option: define SP_CLAMP_EN to add SP_MIN/SP_MAX and clamp every captured target into that range.
module setpoint_ramp_sel #(
    parameter int WIDTH = 12,
    parameter int NUM_SP = 8,
    parameter int DIV = 4,
    parameter logic [WIDTH-1:0] INIT = '0
`ifdef SP_CLAMP_EN
    ,
    parameter logic [WIDTH-1:0] SP_MIN = '0,
    parameter logic [WIDTH-1:0] SP_MAX = '1
`endif
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_SP*WIDTH-1:0]                       sp_bus,
    input  logic [((NUM_SP > 2) ? $clog2(NUM_SP) : 1)-1:0] sel,
    input  logic                                          sel_valid,
    input  logic [WIDTH-1:0]                              step,
    output logic [WIDTH-1:0]                              y,
    output logic                                          busy,
    output logic                                          done
);
    localparam int SELW = (NUM_SP > 2) ? $clog2(NUM_SP) : 1;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

    typedef enum logic {S_IDLE, S_RAMP} state_t;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_y, r_target, w_tgt_nx, w_raw, w_new_tgt, w_y_step, w_y_upd;
    logic [WIDTH:0]   w_step_eff, w_dist, w_move;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic             r_busy, r_done, w_done_nx, w_tick, w_up;

    // Out-of-range indices fall through to the last entry, which is the default.
    always_comb begin
        w_raw = sp_bus[(NUM_SP-1)*WIDTH +: WIDTH];
        for (int k = 0; k < NUM_SP - 1; k++)
            if (sel == SELW'(k)) w_raw = sp_bus[k*WIDTH +: WIDTH];
    end

`ifdef SP_CLAMP_EN
    assign w_new_tgt = (w_raw < SP_MIN) ? SP_MIN : (w_raw > SP_MAX) ? SP_MAX : w_raw;
`else
    assign w_new_tgt = w_raw;
`endif

    // Move is limited to the remaining distance, so y lands exactly on target and never wraps.
    assign w_up       = r_target > r_y;
    assign w_step_eff = (step == '0) ? (WIDTH+1)'(1) : {1'b0, step};
    assign w_dist     = w_up ? {1'b0, r_target} - {1'b0, r_y} : {1'b0, r_y} - {1'b0, r_target};
    assign w_move     = (w_step_eff < w_dist) ? w_step_eff : w_dist;
    assign w_y_step   = WIDTH'(w_up ? {1'b0, r_y} + w_move : {1'b0, r_y} - w_move);
    assign w_tick     = (r_state == S_RAMP) && (r_cnt == LAST_CNT);
    assign w_y_upd    = w_tick ? w_y_step : r_y;

    // The tick update is applied before a coincident strobe is compared against y.
    always_comb begin
        w_state_nx = r_state;
        w_tgt_nx   = r_target;
        w_done_nx  = 1'b0;
        w_cnt_nx   = (r_state == S_RAMP && !w_tick) ? r_cnt + 1'b1 : '0;
        if (sel_valid) begin
            w_tgt_nx   = w_new_tgt;
            w_state_nx = (w_new_tgt == w_y_upd) ? S_IDLE : S_RAMP;
            w_done_nx  = (w_new_tgt == w_y_upd);
        end else if (r_state == S_RAMP && w_y_upd == r_target) begin
            w_state_nx = S_IDLE;
            w_done_nx  = 1'b1;
        end
        // A fresh ramp (from idle, or right after completing) restarts the prescaler; a retarget does not.
        if (w_state_nx == S_IDLE || (sel_valid && w_y_upd == r_target)) w_cnt_nx = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_y      <= INIT;
            r_target <= INIT;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_y      <= w_y_upd;
            r_target <= w_tgt_nx;
            r_cnt    <= w_cnt_nx;
            r_busy   <= (w_state_nx == S_RAMP);
            r_done   <= w_done_nx;
        end
    end

    assign y    = r_y;
    assign busy = r_busy;
    assign done = r_done;
endmodule

// File: tb/tb_setpoint_ramp_sel.sv
// tb_setpoint_ramp_sel: directed self-checking bench for setpoint_ramp_sel.
module tb_setpoint_ramp_sel;
    localparam int W = 12;
    localparam int N = 6;
    localparam int D = 4;
`ifdef SP_CLAMP_EN
    localparam int HI = 2000;
    localparam int Y5 = 2000;
`else
    localparam int HI = 4000;
    localparam int Y5 = 2120;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sel_valid = 1'b0;
    logic [2:0]     sel = '0;
    logic [W-1:0]   step = '0;
    logic [W-1:0]   y;
    logic           busy, done;
    logic [W-1:0]   sp [N];
    logic [N*W-1:0] sp_bus;
    int             checks = 0;
    int             errors = 0;
    int             cur = 0;
    int             nd = 0;
    int             dc = 0;

    always #5 clk = ~clk;

    always_comb begin
        sp_bus = '0;
        for (int k = 0; k < N; k++) sp_bus[k*W +: W] = sp[k];
    end

    setpoint_ramp_sel #(
        .WIDTH(W), .NUM_SP(N), .DIV(D), .INIT(12'd0)
`ifdef SP_CLAMP_EN
        , .SP_MAX(12'd2000)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .sp_bus(sp_bus), .sel(sel), .sel_valid(sel_valid),
        .step(step), .y(y), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic strobe(input int s);
        sel = 3'(s);
        sel_valid = 1'b1;
        cur = 0;
    endtask

    task automatic at(input int t);
        while (cur < t) begin
            @(posedge clk);
            #1;
            sel_valid = 1'b0;
            cur++;
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) sp[k] = '0;
        sp[0] = 12'd77;
        step = 12'd30;
        #3;
        chk("rst_y", y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cur = 0;
        at(8);
        chk("release_y", y, 0);
        chk("release_busy", busy, 0);

        sp[2] = 12'd100;
        strobe(2);
        for (int c = 1; c <= 18; c++) begin
            at(c);
            if (c == 2) sp[2] = 12'd50;
            chk("up_y", y, c < 5 ? 0 : c < 9 ? 30 : c < 13 ? 60 : c < 17 ? 90 : 100);
            chk("up_busy", busy, c <= 16);
            chk("up_done", done, c == 17);
        end

        sp[0] = 12'd0;
        step = 12'd0;
        strobe(0);
        for (int c = 1; c <= 403; c++) begin
            at(c);
            if (done) begin nd++; dc = c; end
            if (c == 4) chk("dec_y4", y, 100);
            if (c == 5) chk("dec_y5", y, 99);
            if (c == 9) chk("dec_y9", y, 98);
        end
        chk("dec_ndone", nd, 1);
        chk("dec_done_cycle", dc, 401);
        chk("dec_y_end", y, 0);
        chk("dec_busy_end", busy, 0);

        sp[1] = 12'd1000;
        sp[3] = 12'd120;
        step = 12'd50;
        strobe(1);
        for (int c = 1; c <= 26; c++) begin
            at(c);
            chk("rev_y", y, c < 5 ? 0 : c < 9 ? 50 : c < 13 ? 100 : c < 17 ? 150 : c < 21 ? 200 : c < 25 ? 150 : 120);
            chk("rev_busy", busy, c <= 24);
            chk("rev_done", done, c == 25);
            if (c == 17) begin sel = 3'd3; sel_valid = 1'b1; end
        end

        sp[4] = 12'd500;
        sp[5] = 12'd180;
        step = 12'd100;
        strobe(7);
        at(4);
        chk("oor_y4", y, 120);
        chk("oor_busy4", busy, 1);
        at(5);
        chk("oor_y5", y, 180);
        chk("oor_busy5", busy, 0);
        chk("oor_done5", done, 1);
        at(6);
        chk("oor_done6", done, 0);

        strobe(5);
        at(1);
        chk("same_busy", busy, 0);
        chk("same_done", done, 1);
        chk("same_y", y, 180);
        at(2);
        chk("same_done2", done, 0);

        sp[0] = 12'd200;
        step = 12'd50;
        strobe(0);
        at(4);
        chk("coin_y4", y, 180);
        sel = 3'd3;
        sel_valid = 1'b1;
        at(5);
        chk("coin_y5", y, 200);
        chk("coin_busy5", busy, 1);
        chk("coin_done5", done, 0);
        at(8);
        chk("coin_y8", y, 200);
        at(9);
        chk("coin_y9", y, 150);
        at(13);
        chk("coin_y13", y, 120);
        chk("coin_done13", done, 1);
        chk("coin_busy13", busy, 0);

        strobe(0);
        at(5);
        chk("land_y5", y, 170);
        at(6);
        sp[2] = 12'd170;
        sel = 3'd2;
        sel_valid = 1'b1;
        at(7);
        chk("land_busy", busy, 0);
        chk("land_done", done, 1);
        at(8);
        chk("land_done2", done, 0);
        at(12);
        chk("land_y12", y, 170);

        sp[1] = 12'd1000;
        strobe(1);
        at(5);
        chk("rmid_y5", y, 220);
        at(6);
        rst_n = 1'b0;
        #2;
        chk("rmid_y", y, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_done", done, 0);
        at(8);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 9; c <= 20; c++) begin
            at(c);
            if (done) nd++;
        end
        chk("rmid_nodone", nd, 0);
        chk("rmid_y_after", y, 0);
        chk("rmid_busy_after", busy, 0);
        strobe(3);
        at(5);
        chk("rnew_y5", y, 50);
        at(9);
        chk("rnew_y9", y, 100);
        at(13);
        chk("rnew_y13", y, 120);
        chk("rnew_done13", done, 1);

        sp[4] = 12'd4000;
        step = 12'd2000;
        strobe(4);
        at(5);
        chk("big_y5", y, Y5);
        at(20);
        chk("big_y_end", y, HI);
        chk("big_busy_end", busy, 0);

`ifndef SP_CLAMP_EN
        sp[5] = 12'd4095;
        step = 12'd4095;
        strobe(5);
        at(5);
        chk("top_y", y, 4095);
        chk("top_done", done, 1);
        sp[0] = 12'd0;
        strobe(0);
        at(5);
        chk("bot_y", y, 0);
        chk("bot_done", done, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
